uart_msg_arbiter: RTL and testbench

- Shares the single byte-level uart_tx transmitter between N_REQ independent message sources, for example the gesture string sender, a confidence/status reporter and a heartbeat.
- Grants are message-atomic: once a requester wins, its bytes go to uart_tx back-to-back until its last byte, so strings never interleave on the serial line.
- Arbitration is round-robin.
- A stall watchdog and a length limit stop a faulty source from holding the line.

---
 rtl/uart_dbg_pkg.sv | 17 +
 rtl/rr_arbiter_pick.sv | 33 +++
 rtl/uart_msg_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_uart_msg_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the UART debug message path.
package uart_dbg_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_BUSY
    } arb_state_t;

    // Index width that stays legal (>= 1 bit) for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arbiter_pick
    import uart_dbg_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        winner = last_grant;
        cand   = '0;
        found  = 1'b0;
        // k = N_REQ wraps back to last_grant itself, so it has lowest priority.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % N_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_msg_arbiter.sv
// Message-atomic round-robin arbiter sharing one uart_tx between several byte sources,
// with a mid-message stall watchdog and a per-grant length limit.
module uart_msg_arbiter
    import uart_dbg_pkg::*;
#(
    parameter int unsigned N_REQ         = 3,
    parameter int unsigned MAX_MSG_BYTES = 16,
    parameter int unsigned STALL_CYCLES  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_busy,
    output logic [idx_width(N_REQ)-1:0] grant_id,
    output logic                      grant_active,
    output logic                      msg_done,
    output logic                      stall_err,
    output logic                      len_err
);

    localparam int unsigned IDX_W   = idx_width(N_REQ);
    localparam int unsigned CNT_W   = $clog2(MAX_MSG_BYTES + 1);
    localparam int unsigned STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   LAST_BYTE_IDX = CNT_W'(MAX_MSG_BYTES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX     = STALL_W'(STALL_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic                grant_active_q, grant_active_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                last_q, last_d;
    logic                forced_q, forced_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                msg_done_q, msg_done_d;
    logic                stall_err_q, stall_err_d;
    logic                len_err_q, len_err_d;

    logic [IDX_W-1:0]    pick_winner;
    logic                pick_any;

    logic [BYTE_W-1:0]   req_bytes [N_REQ];
    logic                sel_valid;
    logic                sel_last;
    logic [BYTE_W-1:0]   sel_data;
    logic                at_limit;

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
    end

    assign sel_valid = req_valid[grant_id_q];
    assign sel_last  = req_last[grant_id_q];
    assign sel_data  = req_bytes[grant_id_q];
    assign at_limit  = (byte_cnt_q == LAST_BYTE_IDX);

    rr_arbiter_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .winner     (pick_winner),
        .any_req    (pick_any)
    );

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        last_grant_d   = last_grant_q;
        grant_active_d = grant_active_q;
        byte_cnt_d     = byte_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        last_d         = last_q;
        forced_d       = forced_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = 1'b0;
        msg_done_d     = 1'b0;
        stall_err_d    = 1'b0;
        len_err_d      = 1'b0;
        req_ready      = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d     = pick_winner;
                    last_grant_d   = pick_winner;
                    grant_active_d = 1'b1;
                    byte_cnt_d     = '0;
                    stall_cnt_d    = '0;
                    state_d        = FETCH;
                end
            end

            FETCH: begin
                // While uart_tx is busy the source is not at fault, so nothing counts.
                if (!tx_busy) begin
                    req_ready[grant_id_q] = 1'b1;
                    if (sel_valid) begin
                        tx_data_d   = sel_data;
                        tx_valid_d  = 1'b1;
                        byte_cnt_d  = byte_cnt_q + 1'b1;
                        last_d      = sel_last || at_limit;
                        forced_d    = !sel_last && at_limit;
                        stall_cnt_d = '0;
                        state_d     = WAIT_BUSY;
                    end else if (stall_cnt_q == STALL_MAX) begin
                        stall_err_d    = 1'b1;
                        grant_active_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
            end

            WAIT_BUSY: begin
                if (tx_busy) begin
                    if (last_q) begin
                        msg_done_d     = !forced_q;
                        len_err_d      = forced_q;
                        grant_active_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_id_q     <= '0;
            last_grant_q   <= IDX_W'(N_REQ - 1);
            grant_active_q <= 1'b0;
            byte_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            last_q         <= 1'b0;
            forced_q       <= 1'b0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            msg_done_q     <= 1'b0;
            stall_err_q    <= 1'b0;
            len_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            last_grant_q   <= last_grant_d;
            grant_active_q <= grant_active_d;
            byte_cnt_q     <= byte_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            last_q         <= last_d;
            forced_q       <= forced_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            msg_done_q     <= msg_done_d;
            stall_err_q    <= stall_err_d;
            len_err_q      <= len_err_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
    assign msg_done     = msg_done_q;
    assign stall_err    = stall_err_q;
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Scoreboard bench for uart_msg_arbiter: requester queues, a uart_tx busy model,
// and an expected-byte queue checked on every tx_valid pulse.
module tb_uart_msg_arbiter;

    localparam int N     = 3;
    localparam int MAXB  = 4;
    localparam int STALL = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           grant_active;
    logic           msg_done;
    logic           stall_err;
    logic           len_err;

    always #5 clk = ~clk;

    uart_msg_arbiter #(
        .N_REQ         (N),
        .MAX_MSG_BYTES (MAXB),
        .STALL_CYCLES  (STALL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .msg_done     (msg_done),
        .stall_err    (stall_err),
        .len_err      (len_err)
    );

    typedef struct packed {logic [7:0] data; logic last;} beat_t;
    typedef struct packed {logic [7:0] data; logic [1:0] gid;} exp_t;

    beat_t  rq[N][$];
    exp_t   exp_q[$];
    logic [N-1:0] acc;

    int n_cmp, n_err;
    int cyc, last_tx_cyc, busy_fall_cyc, busy_left, stall_cyc;
    int tx_cnt, done_cnt, len_cnt, stall_cnt;
    bit start_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_req(input int r, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        rq[r].push_back(b);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [1:0] g);
        exp_t e;
        e.data = d;
        e.gid  = g;
        exp_q.push_back(e);
    endtask

    // One clock: observe outputs at the falling edge, advance models, redrive inputs.
    task automatic step();
        logic busy_prev;
        exp_t e;
        @(negedge clk);
        cyc++;
        busy_prev = tx_busy;
        if (tx_valid) begin
            tx_cnt++;
            check("tx_valid_while_busy", 32'(busy_prev), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_tx", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.data));
                check("tx_gid", 32'(grant_id), 32'(e.gid));
            end
            last_tx_cyc = cyc;
        end
        if (msg_done) begin
            done_cnt++;
            check("done_latency", cyc - last_tx_cyc, 2);
        end
        if (len_err) begin
            len_cnt++;
            check("len_latency", cyc - last_tx_cyc, 2);
        end
        if (stall_err) begin
            stall_cnt++;
            stall_cyc = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) busy_fall_cyc = cyc;
        end
        if (start_pend) begin
            busy_left  = 10;
            start_pend = 1'b0;
        end
        if (tx_valid) start_pend = 1'b1;
        tx_busy = (busy_left > 0);
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = rq[i][0].data;
                req_last[i]        = rq[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        #1;
        acc = req_ready & req_valid;
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (exp_q.size() == 0) && !grant_active && (busy_left == 0) && !start_pend;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!all_idle() && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 3000), 1);
    endtask

    task automatic wait_grant(input string tag, input int g);
        int n;
        n = 0;
        while (!(grant_active && grant_id == 2'(g)) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_grant_timeout"}, 32'(n < 200), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
        check({tag, "_grant_active"}, 32'(grant_active), 0);
        check({tag, "_msg_done"}, 32'(msg_done), 0);
        check({tag, "_stall_err"}, 32'(stall_err), 0);
        check({tag, "_len_err"}, 32'(len_err), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int b_done, b_len, b_stall, b_tx, n;
        logic [7:0] down [6];
        n_cmp = 0; n_err = 0; cyc = 0; last_tx_cyc = 0; busy_fall_cyc = 0;
        busy_left = 0; stall_cyc = 0; tx_cnt = 0; done_cnt = 0; len_cnt = 0;
        stall_cnt = 0; start_pend = 1'b0; acc = '0;
        req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;

        // Single message "UP\r\n"
        push_req(0, 8'h55, 1'b0); push_req(0, 8'h50, 1'b0);
        push_req(0, 8'h0D, 1'b0); push_req(0, 8'h0A, 1'b1);
        push_exp(8'h55, 0); push_exp(8'h50, 0); push_exp(8'h0D, 0); push_exp(8'h0A, 0);
        wait_idle("single");
        check("single_done_cnt", done_cnt, 1);
        check("single_tx_cnt", tx_cnt, 4);

        // Contention from reset: 0, 1, 2 in order, no interleaving
        rst = 1'b1;
        push_req(0, 8'hAA, 1'b0); push_req(0, 8'hA1, 1'b1);
        push_req(1, 8'hBB, 1'b0); push_req(1, 8'hB1, 1'b1);
        push_req(2, 8'hCC, 1'b0); push_req(2, 8'hC1, 1'b1);
        push_exp(8'hAA, 0); push_exp(8'hA1, 0);
        push_exp(8'hBB, 1); push_exp(8'hB1, 1);
        push_exp(8'hCC, 2); push_exp(8'hC1, 2);
        step(); step();
        rst = 1'b0;
        wait_idle("contention");
        check("contention_done_cnt", done_cnt, 4);

        // Fairness: 0 re-requests at once while 1 waits; 1 must go before 0 again
        push_req(0, 8'h10, 1'b0); push_req(0, 8'h11, 1'b1);
        push_req(0, 8'h12, 1'b0); push_req(0, 8'h13, 1'b1);
        push_exp(8'h10, 0); push_exp(8'h11, 0);
        wait_grant("fair0", 0);
        push_req(1, 8'h20, 1'b0); push_req(1, 8'h21, 1'b1);
        push_exp(8'h20, 1); push_exp(8'h21, 1);
        push_exp(8'h12, 0); push_exp(8'h13, 0);
        wait_idle("fairness");
        check("fairness_done_cnt", done_cnt, 7);

        // Stall: requester 1 sends one byte then goes silent, 2 is waiting
        b_done = done_cnt; b_len = len_cnt; b_stall = stall_cnt;
        push_req(1, 8'h31, 1'b0);
        push_exp(8'h31, 1);
        wait_grant("stall1", 1);
        push_req(2, 8'h41, 1'b0); push_req(2, 8'h42, 1'b1);
        push_exp(8'h41, 2); push_exp(8'h42, 2);
        n = 0;
        while (!stall_err && n < 400) begin
            step();
            n++;
        end
        check("stall_seen", 32'(stall_err), 1);
        check("stall_delay", stall_cyc - busy_fall_cyc, STALL);
        check("stall_gact_low", 32'(grant_active), 0);
        step();
        check("stall_next_gact", 32'(grant_active), 1);
        check("stall_next_gid", 32'(grant_id), 2);
        wait_idle("stall");
        check("stall_cnt", stall_cnt - b_stall, 1);
        check("stall_done_cnt", done_cnt - b_done, 1);
        check("stall_len_cnt", len_cnt - b_len, 0);

        // Length limit: 6 bytes, last never set; 4 go out, then 2 under a new grant
        b_done = done_cnt; b_len = len_cnt; b_stall = stall_cnt; b_tx = tx_cnt;
        for (int i = 0; i < 6; i++) begin
            push_req(0, 8'h60 + 8'(i), 1'b0);
            push_exp(8'h60 + 8'(i), 0);
        end
        wait_idle("length");
        check("length_len_cnt", len_cnt - b_len, 1);
        check("length_done_cnt", done_cnt - b_done, 0);
        check("length_tail_stall", stall_cnt - b_stall, 1);
        check("length_tx_cnt", tx_cnt - b_tx, 6);

        // Reset after the 2nd byte of "DOWN\r\n"
        b_done = done_cnt; b_len = len_cnt; b_stall = stall_cnt; b_tx = tx_cnt;
        down[0] = 8'h44; down[1] = 8'h4F; down[2] = 8'h57;
        down[3] = 8'h4E; down[4] = 8'h0D; down[5] = 8'h0A;
        for (int i = 0; i < 6; i++) begin
            push_req(0, down[i], i == 5);
            push_exp(down[i], 0);
        end
        n = 0;
        while (tx_cnt < b_tx + 2 && n < 200) begin
            step();
            n++;
        end
        check("rstmid_reach_2nd", tx_cnt - b_tx, 2);
        rst = 1'b1;
        step();
        check_all_zero("rstmid");
        rst = 1'b0;
        step();
        check("rstmid_gact", 32'(grant_active), 1);
        check("rstmid_gid", 32'(grant_id), 0);
        wait_idle("rstmid");
        check("rstmid_done_cnt", done_cnt - b_done, 1);
        check("rstmid_len_cnt", len_cnt - b_len, 0);
        check("rstmid_stall_cnt", stall_cnt - b_stall, 0);

        check("exp_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
